// File: rtl/handshake_data_memory.sv
// Word-addressed data memory responding on a valid/ready request/response pair.
// Each access takes a fixed LATENCY so the requesting datapath has to stall.
module handshake_data_memory #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_din_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_dout_o,
    output logic        resp_err_o
);
    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [31:0] LIMIT    = 32'(4 * MEM_WORDS);
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic [31:0] dout_q;
    logic        err_q;
    logic [31:0] mem_q [MEM_WORDS];

    logic          err_d;
    logic [AW-1:0] idx_d;

    // Out-of-range addresses never index memory because err_d gates the access.
    assign err_d = (addr_q[1:0] != 2'b00) || (addr_q >= LIMIT);
    assign idx_d = addr_q[AW+1:2];

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_dout_o  = dout_q;
    assign resp_err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        din_q   <= req_din_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        // Store commits here, before RESP becomes visible.
                        state_q <= RESP;
                        err_q   <= err_d;
                        dout_q  <= '0;
                        if (!err_d) begin
                            if (write_q) mem_q[idx_d] <= din_q;
                            else         dout_q       <= mem_q[idx_d];
                        end
                    end
                end
                RESP: begin
                    if (resp_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_data_memory.sv
// Bench: directed + random transactions against an array model, plus a LATENCY=1 instance.
module tb_handshake_data_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv = 1'b0, rw = 1'b0, rr = 1'b1;
    logic [31:0] ra = '0, rd = '0;
    logic        rdy4, vld4, err4;
    logic [31:0] dout4;
    logic        rv1 = 1'b0, rw1 = 1'b0, rr1 = 1'b1;
    logic [31:0] ra1 = '0, rd1 = '0;
    logic        rdy1, vld1, err1;
    logic [31:0] dout1;

    int ncmp = 0;
    int nfail = 0;
    logic [31:0] mem_m [1024];

    always #5 clk = ~clk;

    handshake_data_memory #(.MEM_WORDS(1024), .LATENCY(4)) dut (
        .clk_i(clk), .reset_i(rst), .req_valid_i(rv), .req_ready_o(rdy4),
        .req_write_i(rw), .req_addr_i(ra), .req_din_i(rd), .resp_valid_o(vld4),
        .resp_ready_i(rr), .resp_dout_o(dout4), .resp_err_o(err4));

    handshake_data_memory #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .req_valid_i(rv1), .req_ready_o(rdy1),
        .req_write_i(rw1), .req_addr_i(ra1), .req_din_i(rd1), .resp_valid_o(vld1),
        .resp_ready_i(rr1), .resp_dout_o(dout1), .resp_err_o(err1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    endtask

    // One full transaction; hold = cycles of response backpressure.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
        logic [31:0] exp_d;
        logic        exp_e;
        int          cyc;
        exp_e = (a[1:0] != 2'b00) || (a >= 32'h1000);
        exp_d = '0;
        if (!exp_e) begin
            if (w) mem_m[a[11:2]] = d;
            else   exp_d = mem_m[a[11:2]];
        end
        @(negedge clk);
        chk("idle_ready", 32'(rdy4), 32'd1);
        rv = 1'b1; rw = w; ra = a; rd = d; rr = (hold == 0);
        @(negedge clk);
        rv = 1'b0; rw = 1'($urandom); ra = $urandom; rd = $urandom;
        chk("busy_ready", 32'(rdy4), 32'd0);
        cyc = 0;
        while (!vld4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd4);
        chk("dout", dout4, exp_d);
        chk("err", 32'(err4), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(vld4), 32'd1);
            chk("bp_ready", 32'(rdy4), 32'd0);
            chk("bp_dout", dout4, exp_d);
            chk("bp_err", 32'(err4), 32'(exp_e));
        end
        rr = 1'b1;
        @(negedge clk);
        chk("post_valid", 32'(vld4), 32'd0);
        chk("post_ready", 32'(rdy4), 32'd1);
        chk("post_dout", dout4, exp_d);
        chk("post_err", 32'(err4), 32'(exp_e));
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(rdy4), 32'd1);
        chk("rst_valid", 32'(vld4), 32'd0);
        chk("rst_dout", dout4, 32'd0);
        chk("rst_err", 32'(err4), 32'd0);

        txn(1'b0, 32'h0, 32'h0, 0);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(1'b0, 32'h10, 32'h0, 0);
        txn(1'b0, 32'h10, 32'h0, 5);
        txn(1'b1, 32'h13, 32'h55AA55AA, 0);
        txn(1'b0, 32'h10, 32'h0, 0);
        txn(1'b0, 32'h1000, 32'h0, 0);
        txn(1'b1, 32'hFFC, 32'hCAFEF00D, 0);
        txn(1'b0, 32'hFFC, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 31)) << 2;
            if (r == 7)      a = a + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h1000 + (32'($urandom_range(0, 1000)) << 2);
            else if (r == 9) a = 32'($urandom_range(1020, 1023)) << 2;
            txn(1'($urandom), a, $urandom, int'($urandom_range(0, 2)));
        end

        // Reset two cycles into a store: it must never respond or commit.
        @(negedge clk);
        rv = 1'b1; rw = 1'b1; ra = 32'h20; rd = 32'h12345678;
        @(negedge clk);
        rv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 6; i++) begin
            chk("rstbusy_valid", 32'(vld4), 32'd0);
            @(negedge clk);
        end
        chk("rstbusy_ready", 32'(rdy4), 32'd1);
        chk("rstbusy_dout", dout4, 32'd0);
        txn(1'b0, 32'h20, 32'h0, 0);
        txn(1'b0, 32'h10, 32'h0, 0);
        txn(1'b0, 32'hFFC, 32'h0, 0);

        // LATENCY=1 instance: valid held high, loads alternate good/misaligned.
        for (int c = 0; c < 18; c++) begin
            if (c % 3 == 0) begin
                rv1 = 1'b1;
                ra1 = (((c / 3) % 2) != 0) ? 32'h3 : 32'h8;
            end
            chk("l1_ready", 32'(rdy1), 32'(c % 3 == 0));
            chk("l1_valid", 32'(vld1), 32'(c % 3 == 2));
            if (c % 3 == 2) begin
                chk("l1_err", 32'(err1), 32'((c / 3) % 2));
                chk("l1_dout", dout1, 32'd0);
            end
            @(negedge clk);
        end
        rv1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/handshake_data_memory.md
Name: handshake_data_memory

Overview:
- Word-addressed data memory that acts as the responder on a valid/ready request/response interface.
- Serves load/store requests issued by the multi-cycle and pipelined CPU datapath through its memory-stage initiator.
- Replaces the single-cycle combinational data memory.
- Models a fixed access latency so the CPU's stall logic can be exercised.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words; index = addr[log2(MEM_WORDS)+1:2].
- LATENCY, 4: cycles from the request-accept edge to resp_valid rising; legal range 1..255.

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_din  in  32  store data
- resp_valid  out  1  response available
- resp_ready  in  1  initiator consumes the response
- resp_dout  out  32  load data (0 for stores and errors)
- resp_err  out  1  misaligned or out-of-range access

Behaviour:
- Single clock (clk); reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset:
  - state = IDLE, counter = 0.
  - req_ready = 1 in the first cycle after reset.
  - resp_valid = 0, resp_dout = 0, resp_err = 0.
  - All memory words cleared to 0.
  - Reset overrides every other input.
- States: IDLE, BUSY, RESP. req_ready = (state == IDLE), combinational from state only. resp_valid = (state == RESP).
- IDLE:
  - Accept occurs at an edge where req_valid && req_ready.
  - On accept, latch req_write, req_addr and req_din; load counter = LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter != 0: decrement counter.
  - If counter == 0: perform the access at this edge and go to RESP.
  - The request inputs are ignored in BUSY.
- Access, performed at the BUSY->RESP edge:
  - err = (addr[1:0] != 0) || (addr >= 4*MEM_WORDS).
  - Load, no error: resp_dout = mem[index]; resp_err = 0.
  - Store, no error: mem[index] = din; resp_dout = 0; resp_err = 0.
  - Error: memory unchanged; resp_dout = 0; resp_err = 1.
- Latency: accept at edge E0 -> resp_valid is high in the cycle after edge E0+LATENCY.
- RESP:
  - resp_valid, resp_dout and resp_err are held stable until resp_valid && resp_ready at an edge; then go to IDLE.
  - Outputs resp_dout and resp_err keep their last values in IDLE; only resp_valid drops.
  - The earliest next accept is one cycle after the response handshake, so there is no back-to-back overlap.
- Reset mid-operation (BUSY or RESP): the transaction is abandoned. A pending store is not committed, and memory is cleared regardless.
- Load after store to the same address: returns the stored value, because the store commits before its RESP is visible.
- resp_ready held high permanently: RESP lasts exactly 1 cycle.
- Request data changing after accept has no effect.

Test Plan:
- Reset then idle: req_ready = 1, resp_valid = 0, resp_dout = 0. A load of addr 0x0 returns 0x00000000 with resp_err = 0.
- Store then load, LATENCY = 4, resp_ready = 1:
  - Store 0xDEADBEEF to 0x10, accepted at edge 0 -> resp_valid high in the cycle after edge 4, resp_dout = 0.
  - Load of 0x10 -> resp_dout = 0xDEADBEEF.
- Backpressure: hold resp_ready = 0 for 5 cycles during a load of 0x10 -> resp_valid and resp_dout stay 0xDEADBEEF and req_ready stays 0. Raise resp_ready -> IDLE the next cycle.
- Errors:
  - Store to 0x13 -> resp_err = 1; a following load of 0x10 still returns 0xDEADBEEF.
  - Load of 0x1000 with MEM_WORDS = 1024 -> resp_err = 1, resp_dout = 0.
- Reset in BUSY: assert reset 2 cycles after accepting a store of 0x12345678 to 0x20 -> resp_valid never rises for it; a later load of 0x20 returns 0.
- LATENCY = 1 build, resp_ready = 1, req_valid held high, alternating loads -> responses one cycle after each accept, accepts spaced every 3 cycles.
